// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO read-side controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int OCC_W      = 2;   // holds occupancy 0..2 of the output buffer

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order output buffer with occupancy report.
// Latency: a word written this cycle is visible at out_dat the next cycle.
// Backpressure: caller must not write when full unless popping in the same cycle.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              pop,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ  <= '0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (clr) begin
            occ <= '0;
        end else begin
            case ({in_vld, pop})
                2'b10: begin
                    if (occ == '0) ent0 <= in_dat;
                    else           ent1 <= in_dat;
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - OCC_W'(1);
                end
                2'b11: begin
                    // Occupancy unchanged: the new word lands behind whatever remains.
                    if (occ == OCC_W'(1)) begin
                        ent0 <= in_dat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= in_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_vld = (occ != '0);
    assign out_dat = ent0;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream, with flush and beat counting.
// Latency: 2 cycles from fifo_rd_en to m_valid; 1 word/cycle sustained.
// Backpressure: m_ready low stops reads once buffer plus in-flight reaches two words.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic [CNT_W-1:0]  rd_count,
    output logic              err_underflow
);

    rd_state_t          state_q;
    rd_state_t          state_d;
    logic               inflight_q;
    logic [OCC_W-1:0]   occ;
    logic               buf_vld;
    logic               pop;
    logic               wr_in;
    logic               buf_clr;
    logic [2:0]         lvl;

    skid_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk     (rd_clk),
        .rst_n   (rd_rst_n),
        .clr     (buf_clr),
        .in_vld  (wr_in),
        .in_dat  (fifo_rd_data),
        .pop     (pop),
        .out_vld (buf_vld),
        .out_dat (m_data),
        .occ     (occ)
    );

    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        m_valid    = 1'b0;
        flush_done = 1'b0;
        buf_clr    = 1'b0;
        wr_in      = 1'b0;
        pop        = 1'b0;
        lvl        = {1'b0, occ} + {2'b0, inflight_q};
        if (rd_rst_n) begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (flush) begin
                        // Flush wins outright: no beat, no read, buffered words dropped.
                        state_d = ST_FLUSH;
                        buf_clr = 1'b1;
                    end else begin
                        m_valid    = buf_vld;
                        pop        = buf_vld && m_ready;
                        wr_in      = inflight_q;
                        fifo_rd_en = !fifo_empty && (lvl < (3'd2 + {2'b0, pop}));
                        if (state_q == ST_IDLE) begin
                            if (fifo_rd_en) state_d = ST_RUN;
                        end else if ((lvl == {2'b0, pop}) && !fifo_rd_en) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    buf_clr    = 1'b1;
                    fifo_rd_en = !fifo_empty;
                    if (fifo_empty && !inflight_q) begin
                        flush_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_q       <= ST_IDLE;
            inflight_q    <= 1'b0;
            rd_count      <= '0;
            err_underflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            if (pop) rd_count <= rd_count + CNT_W'(1);
            if (fifo_rd_en && fifo_empty) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural 1-cycle-latency FIFO.
// A second instance with a 4-bit counter shares all inputs to exercise count wrap.
module tb_fifo_rd_ctrl;

    localparam int DW = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          m_ready = 1'b0;
    logic          flush = 1'b0;

    logic          fifo_rd_en, m_valid, flush_done, err_underflow;
    logic [DW-1:0] m_data;
    logic [15:0]   rd_count;

    logic          fifo_rd_en4, m_valid4, flush_done4, err_underflow4;
    logic [DW-1:0] m_data4;
    logic [3:0]    rd_count4;

    fifo_rd_ctrl #(.DATA_W(DW), .CNT_W(16)) u_dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .flush(flush), .flush_done(flush_done),
        .rd_count(rd_count), .err_underflow(err_underflow)
    );

    fifo_rd_ctrl #(.DATA_W(DW), .CNT_W(4)) u_dut4 (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en4), .m_valid(m_valid4),
        .m_data(m_data4), .m_ready(m_ready), .flush(flush), .flush_done(flush_done4),
        .rd_count(rd_count4), .err_underflow(err_underflow4)
    );

    always #5 rd_clk = ~rd_clk;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            n_rd = 0;
    int            n_done = 0;
    int            stable_bad = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] rx_dat[$];
    int            rx_cyc[$];
    logic          s_rd_en, s_vld, s_done;
    logic [DW-1:0] s_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then model the FIFO after the rising edge.
    task automatic cycle();
        @(negedge rd_clk);
        s_rd_en = fifo_rd_en;
        s_vld   = m_valid;
        s_dat   = m_data;
        s_done  = flush_done;
        if (fifo_rd_en) n_rd++;
        if (flush_done) n_done++;
        if (m_valid && m_ready) begin
            rx_dat.push_back(m_data);
            rx_cyc.push_back(cyc);
        end
        @(posedge rd_clk);
        #1;
        if (s_rd_en && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic clear_rx();
        rx_dat.delete();
        rx_cyc.delete();
    endtask

    task automatic chk_stream(input string tag, input int base, input int n);
        logic [DW-1:0] got;
        chk({tag, "_len"}, rx_dat.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < rx_dat.size()) ? rx_dat[i] : 16'hFFFF;
            chk({tag, "_word"}, got, base + i);
        end
    endtask

    initial begin
        // Reset: outputs idle even when the FIFO has data.
        run(2);
        chk("rst_rd_en", s_rd_en, 0);
        chk("rst_vld", s_vld, 0);
        chk("rst_done", s_done, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_count", rd_count, 0);
        chk("rst_err", err_underflow, 0);
        load(100, 10);
        cycle();
        chk("rst_rd_en_nonempty", s_rd_en, 0);
        chk("rst_vld_nonempty", s_vld, 0);

        // Preloaded 100..109 with m_ready high: back-to-back delivery.
        rd_rst_n = 1'b1;
        m_ready  = 1'b1;
        clear_rx();
        run(14);
        chk_stream("stream", 100, 10);
        chk("stream_gapless", (rx_cyc.size() == 10) ? rx_cyc[9] - rx_cyc[0] : 0, 9);
        chk("stream_count", rd_count, 10);

        // m_ready low for 5 cycles: only two reads, head word held.
        m_ready = 1'b0;
        clear_rx();
        n_rd = 0;
        load(100, 10);
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_vld && s_dat !== 16'd100) stable_bad++;
        end
        chk("stall_reads", n_rd, 2);
        chk("stall_vld", s_vld, 1);
        chk("stall_head", s_dat, 100);
        chk("stall_stable", stable_bad, 0);
        m_ready = 1'b1;
        run(15);
        chk_stream("stall_resume", 100, 10);
        chk("stall_count", rd_count, 20);

        // m_ready toggling every cycle over 20 words.
        clear_rx();
        load(200, 20);
        for (int i = 0; i < 60; i++) begin
            m_ready = (i % 2 == 0);
            cycle();
        end
        chk_stream("toggle", 200, 20);
        chk("toggle_count", rd_count, 40);
        chk("toggle_count4", rd_count4, 8);
        chk("toggle_err", err_underflow, 0);

        // Flush with one word buffered, one in flight and five left in the FIFO.
        // (Buffer plus in-flight never exceeds two words, so this is the fullest such state.)
        m_ready = 1'b0;
        load(300, 7);
        run(2);
        clear_rx();
        n_rd   = 0;
        n_done = 0;
        m_ready = 1'b1;
        flush   = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        chk("flush_vld_next", s_vld, 0);
        cycle();
        flush = 1'b1;   // ignored while already flushing
        cycle();
        flush = 1'b0;
        run(10);
        chk("flush_reads", n_rd, 5);
        chk("flush_done_pulses", n_done, 1);
        chk("flush_no_beats", rx_dat.size(), 0);
        chk("flush_count", rd_count, 40);
        chk("flush_err", err_underflow, 0);

        // Reset for one cycle mid-stream: buffered/in-flight words dropped.
        clear_rx();
        load(400, 10);
        run(5);
        chk_stream("pre_rst", 400, 3);
        rd_rst_n = 1'b0;
        cycle();
        chk("midrst_rd_en", s_rd_en, 0);
        chk("midrst_vld", s_vld, 0);
        chk("midrst_done", s_done, 0);
        rd_rst_n = 1'b1;
        chk("postrst_count", rd_count, 0);
        chk("postrst_vld", m_valid, 0);
        chk("postrst_mdata", m_data, 0);
        chk("postrst_err", err_underflow, 0);
        clear_rx();
        run(15);
        chk_stream("post_rst", 405, 5);
        chk("post_rst_count", rd_count, 5);

        // 17 transfers since reset: 4-bit counter wraps to 1.
        clear_rx();
        load(500, 12);
        run(20);
        chk_stream("wrap", 500, 12);
        chk("wrap_count16", rd_count, 17);
        chk("wrap_count4", rd_count4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of FIFO read data and output stream data.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of delivered-word counter.
REQ-003 SHALL have port rd_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rd_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fifo_empty  input  1  FIFO read-side empty flag.
REQ-006 SHALL have port fifo_rd_data  input  DATA_W  FIFO read data, valid the cycle after an accepted fifo_rd_en.
REQ-007 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-008 SHALL have port m_valid  output  1  output stream word valid.
REQ-009 SHALL have port m_data  output  DATA_W  output stream word.
REQ-010 SHALL have port m_ready  input  1  downstream accepts word.
REQ-011 SHALL have port flush  input  1  single-cycle request to discard all buffered and FIFO contents.
REQ-012 SHALL have port flush_done  output  1  one-cycle pulse when flush completes.
REQ-013 SHALL have port rd_count  output  CNT_W  number of words delivered on the stream.
REQ-014 SHALL have port err_underflow  output  1  sticky flag: read issued while FIFO empty.

Function
REQ-015 SHALL hold a 2-entry output buffer (FIFO order) plus one in-flight flag for the 1-cycle FIFO read latency.
REQ-016 SHALL drive m_valid high whenever the buffer holds >=1 word in states IDLE/RUN, with m_data = oldest entry.
REQ-017 SHALL treat a beat as transferred when m_valid && m_ready; oldest entry then popped same edge.
REQ-018 SHALL hold m_data stable while m_valid && !m_ready.
REQ-019 SHALL assert fifo_rd_en in IDLE/RUN iff !fifo_empty && (occupancy + inflight - pop) < 2, pop being this cycle's transfer (combinational m_ready path allowed).
REQ-020 SHALL set inflight on cycle after fifo_rd_en and write fifo_rd_data into buffer on that cycle; sustained throughput 1 word/cycle when FIFO non-empty and m_ready high.
REQ-021 SHALL never overflow the buffer; simultaneous write-in and pop leaves occupancy unchanged.
REQ-022 SHALL implement FSM states IDLE (occupancy 0, no inflight), RUN (data buffered or inflight), FLUSH.
REQ-023 SHALL transition IDLE->RUN on fifo_rd_en; RUN->IDLE when occupancy and inflight reach 0; IDLE/RUN->FLUSH on flush=1 (flush has priority over all other events).
REQ-024 SHALL in FLUSH: force m_valid=0, clear buffer, discard inflight word, assert fifo_rd_en whenever !fifo_empty.
REQ-025 SHALL leave FLUSH to IDLE when fifo_empty=1 and no inflight, pulsing flush_done for exactly that cycle; flush asserted while in FLUSH is ignored.
REQ-026 SHALL increment rd_count by 1 per transferred beat, wrap modulo 2^CNT_W, not count flushed words.
REQ-027 SHALL set err_underflow if fifo_rd_en && fifo_empty ever occurs; cleared only by reset.

Reset
REQ-028 SHALL on rd_rst_n=0 at a rising edge: state IDLE, buffer occupancy 0, inflight 0, rd_count 0, err_underflow 0.
REQ-029 SHALL drive fifo_rd_en=0, m_valid=0, flush_done=0 while rd_rst_n=0; m_data reset to 0.
REQ-030 SHALL, if reset occurs mid-transfer, drop buffered and inflight words without counting them.

Structure
REQ-031 SHALL place FSM state encoding (IDLE, RUN, FLUSH) and default widths in shared package fifo_pkg.
REQ-032 SHALL instantiate one sub-module, skid_buf2 (2-entry valid/ready buffer with occupancy output); all other logic in fifo_rd_ctrl.

Verification
REQ-033 SHALL cover: FIFO preloaded with 100..109, m_ready=1 -> m_data 100..109 on consecutive cycles, rd_count=10, no gaps after first word.
REQ-034 SHALL cover: 10 words available, m_ready held 0 for 5 cycles -> fifo_rd_en issues exactly 2 reads, m_data stays 100, no loss after m_ready=1.
REQ-035 SHALL cover: m_ready toggling 1/0 each cycle over 20 words -> all 20 delivered in order, rd_count=20, err_underflow=0.
REQ-036 SHALL cover: flush with 2 buffered, 1 inflight, 5 in FIFO -> m_valid=0 next cycle, 5 extra reads, flush_done single pulse, rd_count unchanged.
REQ-037 SHALL cover: rd_count preset path (CNT_W=4) with 17 transfers -> rd_count=1 (wrap).
REQ-038 SHALL cover: rd_rst_n=0 for 1 cycle mid-stream -> all outputs at reset values next cycle, streaming resumes from next FIFO word.
